// File: rtl/cond_flag_stage_if.sv
// rtl/cond_flag_stage_if.sv - instruction handshake, retire handshake and cpsr flag bus
`ifndef FLAGSW
`define FLAGSW 4
`endif
`ifndef FULLW
`define FULLW 32
`endif
`ifndef FLAGS_START
`define FLAGS_START 28
`endif

interface cond_flag_stage_if #(parameter int CNTW = 16);
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         in_cond;
   logic               in_s;
   logic [`FLAGSW-1:0] in_flags;
   logic [`FLAGSW-1:0] in_flag_mask;
   logic [`FULLW-1:0]  cpsr_q;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic               out_pass;
   logic [`FLAGSW-1:0] should_set_cpsr;
   logic [`FLAGSW-1:0] cpsrwd;
   logic [CNTW-1:0]    skip_count;

   modport master (
      output in_valid, in_cond, in_s, in_flags, in_flag_mask, cpsr_q, flush, out_ready,
      input  in_ready, out_valid, out_pass, should_set_cpsr, cpsrwd, skip_count
   );

   modport slave (
      input  in_valid, in_cond, in_s, in_flags, in_flag_mask, cpsr_q, flush, out_ready,
      output in_ready, out_valid, out_pass, should_set_cpsr, cpsrwd, skip_count
   );
endinterface

// File: rtl/cond_flag_stage.sv
// rtl/cond_flag_stage.sv - ARM condition evaluation and flag writeback stage feeding cpsr32
`ifndef FLAGSW
`define FLAGSW 4
`endif
`ifndef FULLW
`define FULLW 32
`endif
`ifndef FLAGS_START
`define FLAGS_START 28
`endif

module cond_flag_stage #(
   parameter int CNTW = 16
) (
   input logic              clk,
   input logic              rst,
   cond_flag_stage_if.slave bus
);
   logic               r_valid;
   logic               r_pass;
   logic               r_s;
   logic [`FLAGSW-1:0] r_mask;
   logic [`FLAGSW-1:0] r_flags;
   logic [CNTW-1:0]    skip_q;

   logic               retire;
   logic               accept;
   logic               fwd;
   logic [`FLAGSW-1:0] cpsr_flags;
   logic [`FLAGSW-1:0] eff;
   logic               eval;
   logic               unused_cpsr;

   assign cpsr_flags  = bus.cpsr_q[`FLAGS_START +: `FLAGSW];
   assign unused_cpsr = &{1'b0, bus.cpsr_q[`FLAGS_START-1:0]};

   assign retire       = r_valid & bus.out_ready & ~bus.flush;
   assign bus.in_ready = ~r_valid | (bus.out_ready & ~bus.flush) | bus.flush;
   assign accept       = bus.in_valid & bus.in_ready;

   // cpsr32 only takes the retiring write at this same edge, so bypass it here
   assign fwd = retire & r_pass & r_s;
   assign eff = fwd ? ((r_flags & r_mask) | (cpsr_flags & ~r_mask)) : cpsr_flags;

   always_comb begin
      logic n, z, c, v;
      n    = eff[3];
      z    = eff[2];
      c    = eff[1];
      v    = eff[0];
      eval = 1'b0;
      case (bus.in_cond)
         4'b0000: eval = z;
         4'b0001: eval = ~z;
         4'b0010: eval = c;
         4'b0011: eval = ~c;
         4'b0100: eval = n;
         4'b0101: eval = ~n;
         4'b0110: eval = v;
         4'b0111: eval = ~v;
         4'b1000: eval = c & ~z;
         4'b1001: eval = ~c | z;
         4'b1010: eval = (n == v);
         4'b1011: eval = (n != v);
         4'b1100: eval = ~z & (n == v);
         4'b1101: eval = z | (n != v);
         4'b1110: eval = 1'b1;
         default: eval = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pass  <= 1'b0;
         r_s     <= 1'b0;
         r_mask  <= '0;
         r_flags <= '0;
      end else if (accept) begin
         r_valid <= 1'b1;
         r_pass  <= eval;
         r_s     <= bus.in_s;
         r_mask  <= bus.in_flag_mask;
         r_flags <= bus.in_flags;
      end else if (retire | bus.flush) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skip_q <= '0;
      end else if (retire & ~r_pass & ~(&skip_q)) begin
         skip_q <= skip_q + 1'b1;
      end
   end

   assign bus.should_set_cpsr = (retire & r_pass & r_s) ? r_mask : '0;
   assign bus.cpsrwd          = r_valid ? r_flags : '0;
   assign bus.out_valid       = r_valid & ~bus.flush;
   assign bus.out_pass        = r_valid & r_pass;
   assign bus.skip_count      = skip_q;
endmodule

// File: tb/tb_cond_flag_stage.sv
// tb/tb_cond_flag_stage.sv - randomized and directed checks of cond_flag_stage against a queue model
`ifndef FLAGS_START
`define FLAGS_START 28
`endif

module tb_cond_flag_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   cond_flag_stage_if #(.CNTW(16)) ifc ();
   cond_flag_stage_if #(.CNTW(2))  ifc2 ();

   cond_flag_stage #(.CNTW(16)) dut  (.clk(clk), .rst(rst), .bus(ifc.slave));
   cond_flag_stage #(.CNTW(2))  dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave));

   typedef struct {
      logic       pass;
      logic       s;
      logic [3:0] mask;
      logic [3:0] flags;
   } instr_t;

   instr_t     pend[$];
   instr_t     m_head;
   logic [3:0] m_cpsr = 4'b0000;
   int         m_skip = 0;
   bit         m_retire;
   bit         m_write;
   logic [3:0] m_next_cpsr;
   logic       exp_in_ready, exp_out_valid, exp_out_pass;
   logic [3:0] exp_set, exp_wd;
   logic [15:0] exp_skip;

   // ARM semantics: even codes name a base test, the odd neighbour is its negation
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n = f[3], z = f[2], cf = f[1], v = f[0];
      bit base;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: return (c == 4'b1110);
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic void model_eval();
      bit have = (pend.size() > 0);
      if (have) m_head = pend[0];
      else m_head = '{pass: 1'b0, s: 1'b0, mask: 4'b0, flags: 4'b0};
      m_retire = have && ifc.out_ready && !ifc.flush;
      m_write  = m_retire && m_head.pass && m_head.s;
      m_next_cpsr = m_cpsr;
      for (int i = 0; i < 4; i++)
         if (m_write && m_head.mask[i]) m_next_cpsr[i] = m_head.flags[i];
      exp_in_ready  = !have || ifc.out_ready || ifc.flush;
      exp_out_valid = have && !ifc.flush;
      exp_out_pass  = have && m_head.pass;
      exp_set       = m_write ? m_head.mask : 4'b0;
      exp_wd        = have ? m_head.flags : 4'b0;
      exp_skip      = 16'(m_skip);
   endfunction

   function automatic void model_update();
      if (rst) return;
      if (m_retire) begin
         m_cpsr = m_next_cpsr;
         if (!m_head.pass && m_skip < 65535) m_skip++;
      end
      if (pend.size() > 0 && (m_retire || ifc.flush)) pend.delete();
      if (ifc.in_valid && exp_in_ready)
         pend.push_back('{pass: cond_ok(ifc.in_cond, m_next_cpsr), s: ifc.in_s,
                          mask: ifc.in_flag_mask, flags: ifc.in_flags});
   endfunction

   task automatic drive(input logic v, input logic [3:0] c, input logic s, input logic [3:0] f,
                        input logic [3:0] m, input logic fl, input logic ordy);
      logic [31:0] word;
      @(negedge clk);
      word = $urandom;
      word[`FLAGS_START +: 4] = m_cpsr;
      ifc.in_valid = v;
      ifc.in_cond = c;
      ifc.in_s = s;
      ifc.in_flags = f;
      ifc.in_flag_mask = m;
      ifc.flush = fl;
      ifc.out_ready = ordy;
      ifc.cpsr_q = word;
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
   endtask

   task automatic drain();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_reset();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", ifc.out_valid); end
      total++; if (ifc.out_pass !== 1'b0) begin bad++; $display("FAIL reset_out_pass got=%0b want=0", ifc.out_pass); end
      total++; if (ifc.should_set_cpsr !== 4'b0) begin bad++; $display("FAIL reset_set got=%b want=0000", ifc.should_set_cpsr); end
      total++; if (ifc.cpsrwd !== 4'b0) begin bad++; $display("FAIL reset_cpsrwd got=%b want=0000", ifc.cpsrwd); end
      total++; if (ifc.skip_count !== 16'd0) begin bad++; $display("FAIL reset_skip got=%0d want=0", ifc.skip_count); end
      total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", ifc.in_ready); end
      tick();
      // a failed instr retires (skip=1) while an AL flag setter is captured
      drive(1'b1, 4'b1111, 1'b1, 4'hf, 4'hf, 1'b0, 1'b1);
      tick();
      drive(1'b1, 4'b1110, 1'b1, 4'hf, 4'hf, 1'b0, 1'b1);
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL prereset_valid got=%0b want=1", ifc.out_valid); end
      total++; if (ifc.skip_count !== 16'd1) begin bad++; $display("FAIL prereset_skip got=%0d want=1", ifc.skip_count); end
      #2 rst = 1'b1;
      #1;
      pend.delete();
      m_skip = 0;
      total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%0b want=0", ifc.out_valid); end
      total++; if (ifc.should_set_cpsr !== 4'b0) begin bad++; $display("FAIL async_set got=%b want=0000", ifc.should_set_cpsr); end
      total++; if (ifc.skip_count !== 16'd0) begin bad++; $display("FAIL async_skip got=%0d want=0", ifc.skip_count); end
      total++; if (ifc.out_pass !== 1'b0) begin bad++; $display("FAIL async_pass got=%0b want=0", ifc.out_pass); end
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      total++; if (ifc.should_set_cpsr !== 4'b0) begin bad++; $display("FAIL inreset_set got=%b want=0000", ifc.should_set_cpsr); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_forwarding();
      drain();
      m_cpsr = 4'b0000;
      drive(1'b1, 4'b1110, 1'b1, 4'b0100, 4'b1111, 1'b0, 1'b1);
      tick();
      drive(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      total++; if (ifc.should_set_cpsr !== 4'b1111) begin bad++; $display("FAIL fwd_set got=%b want=1111", ifc.should_set_cpsr); end
      total++; if (ifc.cpsrwd !== 4'b0100) begin bad++; $display("FAIL fwd_wd got=%b want=0100", ifc.cpsrwd); end
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      total++; if (ifc.out_pass !== 1'b1) begin bad++; $display("FAIL fwd_eq_pass got=%0b want=1", ifc.out_pass); end
      total++; if (ifc.should_set_cpsr !== 4'b0) begin bad++; $display("FAIL fwd_b_set got=%b want=0000", ifc.should_set_cpsr); end
      tick();
   endtask

   task automatic test_stall();
      drain();
      drive(1'b1, 4'b1110, 1'b1, 4'b1010, 4'b1111, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
         total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%0b want=0", k, ifc.in_ready); end
         total++; if (ifc.should_set_cpsr !== 4'b0) begin bad++; $display("FAIL stall_set[%0d] got=%b want=0000", k, ifc.should_set_cpsr); end
         tick();
      end
      drive(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      total++; if (ifc.should_set_cpsr !== 4'b1111) begin bad++; $display("FAIL stall_release_set got=%b want=1111", ifc.should_set_cpsr); end
      total++; if (ifc.cpsrwd !== 4'b1010) begin bad++; $display("FAIL stall_release_wd got=%b want=1010", ifc.cpsrwd); end
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      total++; if (ifc.should_set_cpsr !== 4'b0) begin bad++; $display("FAIL stall_single_write got=%b want=0000", ifc.should_set_cpsr); end
      total++; if (ifc.out_pass !== 1'b0) begin bad++; $display("FAIL stall_eq_pass got=%0b want=0", ifc.out_pass); end
      tick();
   endtask

   task automatic test_cond_table();
      logic prev_exp;
      logic [3:0] pc, pf;
      drain();
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            m_cpsr = 4'(f);
            drive(1'b1, 4'(c), 1'b0, 4'($urandom), 4'($urandom), 1'b0, 1'b1);
            if (c != 0 || f != 0) begin
               total++; if (ifc.out_pass !== prev_exp) begin bad++; $display("FAIL cond_table cond=%b nzcv=%b got=%0b want=%0b", pc, pf, ifc.out_pass, prev_exp); end
               total++; if (ifc.skip_count !== exp_skip) begin bad++; $display("FAIL cond_skip got=%0d want=%0d", ifc.skip_count, exp_skip); end
            end
            prev_exp = cond_ok(4'(c), 4'(f));
            pc = 4'(c);
            pf = 4'(f);
            tick();
         end
      end
      drive(1'b1, 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1);
      total++; if (ifc.out_pass !== prev_exp) begin bad++; $display("FAIL cond_table_last got=%0b want=%0b", ifc.out_pass, prev_exp); end
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      total++; if (ifc.should_set_cpsr !== 4'b0) begin bad++; $display("FAIL never_s_set got=%b want=0000", ifc.should_set_cpsr); end
      total++; if (ifc.out_pass !== 1'b0) begin bad++; $display("FAIL never_pass got=%0b want=0", ifc.out_pass); end
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      total++; if (ifc.skip_count !== exp_skip) begin bad++; $display("FAIL never_skip got=%0d want=%0d", ifc.skip_count, exp_skip); end
      tick();
   endtask

   task automatic test_mask();
      drain();
      m_cpsr = 4'b0000;
      drive(1'b1, 4'b1110, 1'b1, 4'b1001, 4'b1110, 1'b0, 1'b1);
      tick();
      drive(1'b1, 4'b0111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      total++; if (ifc.should_set_cpsr !== 4'b1110) begin bad++; $display("FAIL mask_set got=%b want=1110", ifc.should_set_cpsr); end
      total++; if (ifc.cpsrwd !== 4'b1001) begin bad++; $display("FAIL mask_wd got=%b want=1001", ifc.cpsrwd); end
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      total++; if (ifc.out_pass !== 1'b1) begin bad++; $display("FAIL mask_v_kept got=%0b want=1", ifc.out_pass); end
      tick();
   endtask

   task automatic test_flush();
      logic [15:0] sk0;
      drain();
      sk0 = exp_skip;
      drive(1'b1, 4'b1110, 1'b1, 4'b0110, 4'b1111, 1'b0, 1'b1);
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
      total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", ifc.out_valid); end
      total++; if (ifc.should_set_cpsr !== 4'b0) begin bad++; $display("FAIL flush_set got=%b want=0000", ifc.should_set_cpsr); end
      total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b want=1", ifc.in_ready); end
      tick();
      drive(1'b1, 4'b1111, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL flush_gone got=%0b want=0", ifc.out_valid); end
      tick();
      drive(1'b1, 4'b1110, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL flush_take_ready got=%0b want=1", ifc.in_ready); end
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL flush_new_valid got=%0b want=1", ifc.out_valid); end
      total++; if (ifc.out_pass !== 1'b1) begin bad++; $display("FAIL flush_new_pass got=%0b want=1", ifc.out_pass); end
      total++; if (ifc.skip_count !== sk0) begin bad++; $display("FAIL flush_skip got=%0d want=%0d", ifc.skip_count, sk0); end
      tick();
   endtask

   task automatic test_random();
      drain();
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
         total++; if (ifc.in_ready !== exp_in_ready) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%0b want=%0b", k, ifc.in_ready, exp_in_ready); end
         total++; if (ifc.out_valid !== exp_out_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%0b want=%0b", k, ifc.out_valid, exp_out_valid); end
         total++; if (ifc.out_pass !== exp_out_pass) begin bad++; $display("FAIL rnd_pass[%0d] got=%0b want=%0b", k, ifc.out_pass, exp_out_pass); end
         total++; if (ifc.should_set_cpsr !== exp_set) begin bad++; $display("FAIL rnd_set[%0d] got=%b want=%b", k, ifc.should_set_cpsr, exp_set); end
         total++; if (ifc.cpsrwd !== exp_wd) begin bad++; $display("FAIL rnd_wd[%0d] got=%b want=%b", k, ifc.cpsrwd, exp_wd); end
         total++; if (ifc.skip_count !== exp_skip) begin bad++; $display("FAIL rnd_skip[%0d] got=%0d want=%0d", k, ifc.skip_count, exp_skip); end
         tick();
      end
   endtask

   task automatic test_saturation();
      drain();
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         ifc2.in_valid = (k < 5);
         #1;
         total++;
         if (ifc2.skip_count !== 2'((k < 1) ? 0 : ((k - 1 > 3) ? 3 : k - 1))) begin
            bad++;
            $display("FAIL sat_skip[%0d] got=%0d want=%0d", k, ifc2.skip_count, (k < 1) ? 0 : ((k - 1 > 3) ? 3 : k - 1));
         end
      end
      ifc2.in_valid = 1'b0;
   endtask

   initial begin
      ifc.in_valid = 1'b0; ifc.in_cond = 4'h0; ifc.in_s = 1'b0; ifc.in_flags = 4'h0;
      ifc.in_flag_mask = 4'h0; ifc.flush = 1'b0; ifc.out_ready = 1'b0; ifc.cpsr_q = '0;
      ifc2.in_valid = 1'b0; ifc2.in_cond = 4'b1111; ifc2.in_s = 1'b1; ifc2.in_flags = 4'hf;
      ifc2.in_flag_mask = 4'hf; ifc2.flush = 1'b0; ifc2.out_ready = 1'b1; ifc2.cpsr_q = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_forwarding();
      test_stall();
      test_cond_table();
      test_mask();
      test_flush();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
